abh_seq: RTL

- Cycle sequencer for the address-bus-high datapath of the 65C02 core.
- Accepts one addressing request from the microcode engine and drives the ABH datapath for 1–2 cycles: operation select, carry-in, force-to-FF, and PC-high load/increment.
- Inserts the page-cross fix-up cycle for indexed and branch addressing automatically.
- Runs the reset-vector sequence after reset.

---
 rtl/abh_seq.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/abh_seq.sv
// -----------------------------------------------------------------------------
// abh_seq -- address-bus-high cycle sequencer for the 65C02 core.
//
// Takes one addressing request from the microcode engine and steers the ABH
// datapath for one or two cycles. A page-cross fix-up cycle is added
// automatically for indexed and branch addressing. After reset it runs the
// two-cycle reset-vector sequence, which forces ABH to FF.
//
// Handshake: start is a request strobe. It is taken on a rising edge only
// when busy=0 and rdy=1. done is high for exactly one cycle, the final
// cycle of a request, and only while rdy=1. With rdy=0 the sequencer holds
// its state and keeps presenting the same datapath operation.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request strobe (accepted only when busy=0)
//   mode[2:0]        addressing mode, latched when start is accepted
//   pc_upd, pc_inc   PC-high load / increment flags, latched with start
//   rdy              memory ready, 0 = stall
//   abl_co           carry out of the low-address adder (same cycle)
//   back             branch offset negative, latched with start
//   op[2:0]          ABH operation: 0xx=00+CI, 100=ABH+CI, 101=ABH+FF+CI,
//                    110=PCH+CI, 111=DB+CI
//   ci, ff           ABH carry-in, force ABH to FF
//   ld_pc, inc_pc    load PCH from ABH, increment applied with that load
//   busy, done       request in progress, final-cycle pulse
//   penalty          current cycle is a fix-up cycle
//   fix_cnt          saturating count of fix-up cycles issued
//   dbg_state        current sequencer state, for observation
// -----------------------------------------------------------------------------
module abh_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic             pc_upd,
  input  logic             pc_inc,
  input  logic             rdy,
  input  logic             abl_co,
  input  logic             back,
  output logic [2:0]       op,
  output logic             ci,
  output logic             ff,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             busy,
  output logic             done,
  output logic             penalty,
  output logic [CNT_W-1:0] fix_cnt,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_VEC0  = 3'd1,
    S_VEC1  = 3'd2,
    S_ISSUE = 3'd3,
    S_FIX   = 3'd4
  } state_t;

  localparam logic [2:0] OP_ZERO = 3'b000;
  localparam logic [2:0] OP_ABH  = 3'b100;
  localparam logic [2:0] OP_ABHF = 3'b101;
  localparam logic [2:0] OP_PCH  = 3'b110;
  localparam logic [2:0] OP_DB   = 3'b111;

  localparam logic [2:0] M_PC_NEXT = 3'b000;
  localparam logic [2:0] M_ZPAGE   = 3'b001;
  localparam logic [2:0] M_STACK   = 3'b010;
  localparam logic [2:0] M_ABS     = 3'b011;
  localparam logic [2:0] M_ABS_IDX = 3'b100;
  localparam logic [2:0] M_BRANCH  = 3'b101;
  localparam logic [2:0] M_VECTOR  = 3'b110;
  localparam logic [2:0] M_HOLD    = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [2:0]       r_mode;
  logic             r_pc_upd;
  logic             r_pc_inc;
  logic             r_back;
  logic             r_fix_dn;   // pending fix-up goes down a page (ABH-1)
  logic [CNT_W-1:0] r_fix_cnt;

  logic             w_final;    // this state ends the request when rdy=1
  logic             w_need_fix; // ISSUE must be followed by a fix-up cycle
  logic             w_fix_dn;   // direction of that fix-up cycle

  // ---------------------------------------------------------------------------
  // Output / decision decode. Everything here depends only on the current
  // state, latched request fields and live inputs, so a stalled cycle keeps
  // presenting the same operation and the fix-up decision is taken from
  // abl_co in whichever cycle rdy finally goes high.
  // ---------------------------------------------------------------------------
  always_comb begin
    op         = OP_ABH;
    ci         = 1'b0;
    ff         = 1'b0;
    busy       = 1'b1;
    penalty    = 1'b0;
    w_final    = 1'b0;
    w_need_fix = 1'b0;
    w_fix_dn   = 1'b0;

    case (r_state)
      S_VEC0: begin
        ff = 1'b1;
      end

      S_VEC1: begin
        ff = 1'b1;
      end

      S_IDLE: begin
        busy = 1'b0;
      end

      S_ISSUE: begin
        case (r_mode)
          M_PC_NEXT: begin
            op      = OP_PCH;
            ci      = abl_co;
            w_final = 1'b1;
          end
          M_ZPAGE: begin
            op      = OP_ZERO;
            w_final = 1'b1;
          end
          M_STACK: begin
            op      = OP_ZERO;
            ci      = 1'b1;
            w_final = 1'b1;
          end
          M_ABS: begin
            op      = OP_DB;
            w_final = 1'b1;
          end
          M_ABS_IDX: begin
            op         = OP_DB;
            w_need_fix = abl_co;
            w_final    = ~abl_co;
          end
          M_BRANCH: begin
            // Forward branch crossing up, or backward branch without a
            // borrow-cancelling carry, lands on the neighbouring page.
            op         = OP_ABH;
            w_need_fix = r_back ^ abl_co;
            w_fix_dn   = r_back;
            w_final    = ~(r_back ^ abl_co);
          end
          M_VECTOR: begin
            ff      = 1'b1;
            w_final = 1'b1;
          end
          M_HOLD: begin
            w_final = 1'b1;
          end
          default: begin
            w_final = 1'b1;
          end
        endcase
      end

      S_FIX: begin
        penalty = 1'b1;
        w_final = 1'b1;
        if (r_fix_dn) begin
          op = OP_ABHF;   // ABH + FF = ABH - 1
          ci = 1'b0;
        end else begin
          op = OP_ABH;
          ci = 1'b1;      // ABH + 1
        end
      end

      default: begin
        ff = 1'b1;
      end
    endcase
  end

  // The vector sequence signals completion in VEC1 but never loads PC.
  assign done      = rdy & (w_final | (r_state == S_VEC1));
  assign ld_pc     = rdy & w_final & r_pc_upd;
  assign inc_pc    = rdy & w_final & r_pc_upd & r_pc_inc;
  assign fix_cnt   = r_fix_cnt;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------------
  // State register. Nothing advances while rdy=0, including request
  // acceptance in IDLE and the fix-up counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_VEC0;
      r_mode    <= 3'b000;
      r_pc_upd  <= 1'b0;
      r_pc_inc  <= 1'b0;
      r_back    <= 1'b0;
      r_fix_dn  <= 1'b0;
      r_fix_cnt <= '0;
    end else if (rdy) begin
      case (r_state)
        S_VEC0: r_state <= S_VEC1;
        S_VEC1: r_state <= S_IDLE;
        S_IDLE: begin
          if (start) begin
            r_mode   <= mode;
            r_pc_upd <= pc_upd;
            r_pc_inc <= pc_inc;
            r_back   <= back;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_need_fix) begin
            r_fix_dn <= w_fix_dn;
            r_state  <= S_FIX;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_FIX: begin
          if (r_fix_cnt != CNT_MAX) begin
            r_fix_cnt <= r_fix_cnt + CNT_ONE;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_VEC0;
      endcase
    end
  end

endmodule
